// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants, state encoding and note period table for the step sequencer
package seq_pkg;

  localparam int CLK_HZ    = 12_000_000;
  localparam int NOTE_W    = 6;
  localparam int NUM_NOTES = 48;
  localparam int REST      = 0;
  localparam int A3_IDX    = 10;
  localparam int PERIOD_W  = 18;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  // Half-period counts round(CLK_HZ/(2*f)) - 1, index 1 = C3, semitone steps; A3 anchors the scale.
  function automatic logic [PERIOD_W-1:0] note_period(input logic [NOTE_W-1:0] idx);
    logic [PERIOD_W-1:0] p;
    case (idx)
      6'd1:  p = 18'd45865;
      6'd2:  p = 18'd43292;
      6'd3:  p = 18'd40862;
      6'd4:  p = 18'd38568;
      6'd5:  p = 18'd36404;
      6'd6:  p = 18'd34360;
      6'd7:  p = 18'd32432;
      6'd8:  p = 18'd30612;
      6'd9:  p = 18'd28893;
      NOTE_W'(A3_IDX): p = PERIOD_W'((CLK_HZ + 220) / 440 - 1);
      6'd11: p = 18'd25741;
      6'd12: p = 18'd24296;
      6'd13: p = 18'd22933;
      6'd14: p = 18'd21645;
      6'd15: p = 18'd20430;
      6'd16: p = 18'd19284;
      6'd17: p = 18'd18201;
      6'd18: p = 18'd17180;
      6'd19: p = 18'd16215;
      6'd20: p = 18'd15305;
      6'd21: p = 18'd14446;
      6'd22: p = 18'd13635;
      6'd23: p = 18'd12870;
      6'd24: p = 18'd12148;
      6'd25: p = 18'd11466;
      6'd26: p = 18'd10822;
      6'd27: p = 18'd10215;
      6'd28: p = 18'd9641;
      6'd29: p = 18'd9100;
      6'd30: p = 18'd8589;
      6'd31: p = 18'd8107;
      6'd32: p = 18'd7652;
      6'd33: p = 18'd7223;
      6'd34: p = 18'd6817;
      6'd35: p = 18'd6435;
      6'd36: p = 18'd6073;
      6'd37: p = 18'd5732;
      6'd38: p = 18'd5411;
      6'd39: p = 18'd5107;
      6'd40: p = 18'd4820;
      6'd41: p = 18'd4550;
      6'd42: p = 18'd4294;
      6'd43: p = 18'd4053;
      6'd44: p = 18'd3826;
      6'd45: p = 18'd3611;
      6'd46: p = 18'd3408;
      6'd47: p = 18'd3217;
      6'd48: p = 18'd3036;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/note_rom.sv
// rtl/note_rom.sv - combinational note index to {valid, counter_top} lookup
import seq_pkg::*;

module note_rom #(
  parameter int WIDTH = 18
) (
  input  logic [NOTE_W-1:0] idx,
  output logic              valid,
  output logic [WIDTH-1:0]  counter_top
);

  assign valid       = (idx != NOTE_W'(REST)) && (idx <= NOTE_W'(NUM_NOTES));
  assign counter_top = WIDTH'(note_period(idx));

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - 16-step pattern player driving one square-wave oscillator voice
import seq_pkg::*;

module note_sequencer #(
  parameter int WIDTH   = 18,
  parameter int STEP_AW = 4,
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [STEP_AW-1:0] loop_len,
  input  logic               wr_en,
  input  logic [STEP_AW-1:0] wr_addr,
  input  logic [NOTE_W-1:0]  wr_data,
  output logic               busy,
  output logic [STEP_AW-1:0] step,
  output logic               step_strobe,
  output logic [WIDTH-1:0]   counter_top,
  output logic               osc_rst,
  output logic               gate
);

  state_t             state, state_next;
  logic [NOTE_W-1:0]  pattern [2**STEP_AW];
  logic [TEMPO_W-1:0] tempo_cnt;
  logic [TEMPO_W-1:0] t_last;
  logic               step_done;
  logic               note_gate;
  logic               rom_valid;
  logic [WIDTH-1:0]   rom_top;

  // Tempo values below 2 behave as 2, so the last count is never below 1.
  assign t_last    = (tempo < TEMPO_W'(2)) ? TEMPO_W'(1) : tempo - TEMPO_W'(1);
  assign step_done = (tempo_cnt >= t_last);

  note_rom #(.WIDTH(WIDTH)) u_note_rom (
    .idx         (pattern[step]),
    .valid       (rom_valid),
    .counter_top (rom_top)
  );

  always_ff @(posedge clk) begin
    if (wr_en) pattern[wr_addr] <= wr_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = PLAY;
      PLAY:    if (step_done) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    if (stop) state_next = IDLE;
  end

  // The note is captured at the end of LOAD, so a same-edge write to that address plays next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      tempo_cnt   <= '0;
      counter_top <= '0;
      note_gate   <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == IDLE) begin
        step      <= '0;
        tempo_cnt <= '0;
        note_gate <= 1'b0;
      end else if (state == LOAD) begin
        tempo_cnt <= TEMPO_W'(1);
        note_gate <= rom_valid;
        if (rom_valid) counter_top <= rom_top;
      end else if (state == PLAY) begin
        tempo_cnt <= tempo_cnt + TEMPO_W'(1);
        if (state_next == LOAD)
          step <= (step >= loop_len) ? '0 : step + STEP_AW'(1);
      end
    end
  end

  assign busy        = (state != IDLE);
  assign step_strobe = (state == LOAD);
  assign gate        = (state == PLAY) && note_gate;
  assign osc_rst     = ~gate;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

  localparam int WIDTH   = 18;
  localparam int STEP_AW = 4;
  localparam int TEMPO_W = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, wr_en;
  logic [TEMPO_W-1:0] tempo;
  logic [STEP_AW-1:0] loop_len, wr_addr;
  logic [5:0]         wr_data;
  logic               busy, step_strobe, osc_rst, gate;
  logic [STEP_AW-1:0] step;
  logic [WIDTH-1:0]   counter_top;

  note_sequencer #(.WIDTH(WIDTH), .STEP_AW(STEP_AW), .TEMPO_W(TEMPO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tempo(tempo),
    .loop_len(loop_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .step(step), .step_strobe(step_strobe),
    .counter_top(counter_top), .osc_rst(osc_rst), .gate(gate)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int top;
    bit gate;
    int period;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe = 0;
  bit   pend = 0;
  bit   mon_en = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic void push(input int s, input int t, input bit g, input int p);
    exp_t e;
    e.step = s; e.top = t; e.gate = g; e.period = p;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (step_strobe) strobe_cnt++;
    if (mon_en && rst_n) begin
      if (pend) begin
        chk("counter_top", counter_top, cur.top);
        chk("note_gate", gate, cur.gate);
        pend = 0;
      end
      if (step_strobe) begin
        chk("strobe_expected", exp_q.size() != 0, 1);
        chk("load_osc_rst", osc_rst, 1);
        chk("load_gate", gate, 0);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("step", step, cur.step);
          if (cur.period > 0) chk("strobe_period", cyc - last_strobe, cur.period);
          pend = 1;
        end
      end else if (busy) begin
        chk("play_step", step, cur.step);
        chk("play_gate", gate, cur.gate);
        chk("play_osc_rst", osc_rst, !cur.gate);
      end
    end
    if (step_strobe) last_strobe = cyc;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic write_step(input int a, input int d);
    @(posedge clk); #1 wr_en = 1; wr_addr = STEP_AW'(a); wr_data = 6'(d);
    @(posedge clk); #1 wr_en = 0;
  endtask

  task automatic wait_strobes(input string tag, input int target);
    int n = 0;
    while (strobe_cnt < target && n < 2000) begin @(posedge clk); n++; end
    chk({tag, "_strobe_wait"}, strobe_cnt >= target, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || pend) && n < 4000) begin @(posedge clk); n++; end
    chk({tag, "_drain"}, exp_q.size() + pend, 0);
    exp_q.delete();
    pend = 0;
  endtask

  task automatic stop_and_check(input string tag);
    #1 mon_en = 0; stop = 1;
    @(posedge clk); #1 stop = 0;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_osc_rst"}, osc_rst, 1);
    chk({tag, "_gate"}, gate, 0);
    mon_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst_n = 0; start = 0; stop = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    tempo = 24'd8; loop_len = 4'd3;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_counter_top", counter_top, 0);
    chk("rst_osc_rst", osc_rst, 1);
    chk("rst_gate", gate, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_strobes", strobe_cnt, 0);
    chk("idle_osc_rst", osc_rst, 1);
    chk("idle_gate", gate, 0);

    write_step(0, 1); write_step(1, 10); write_step(2, 0); write_step(3, 10);

    push(0, 45865, 1, 0); push(1, 27272, 1, 8); push(2, 27272, 0, 8);
    push(3, 27272, 1, 8); push(0, 45865, 1, 8);
    pulse_start();
    drain("basic");
    stop_and_check("stop_play");

    tempo = 24'd0;
    push(0, 45865, 1, 0); push(1, 27272, 1, 2); push(2, 27272, 0, 2);
    push(3, 27272, 1, 2); push(0, 45865, 1, 2);
    pulse_start();
    drain("tempo0");
    stop_and_check("tempo0_stop");

    tempo = 24'd1;
    push(0, 45865, 1, 0); push(1, 27272, 1, 2); push(2, 27272, 0, 2);
    push(3, 27272, 1, 2); push(0, 45865, 1, 2); push(1, 27272, 1, 2);
    pulse_start();
    drain("tempo1");
    stop_and_check("tempo1_stop");

    tempo = 24'd100;
    s0 = strobe_cnt;
    push(0, 45865, 1, 0); push(1, 27272, 1, 51); push(2, 27272, 0, 5);
    pulse_start();
    wait_strobes("tempo_chg", s0 + 1);
    repeat (49) @(posedge clk);
    #1 tempo = 24'd5;
    drain("tempo_chg");
    stop_and_check("tempo_chg_stop");
    tempo = 24'd8;

    s0 = strobe_cnt;
    @(posedge clk); #1 start = 1; stop = 1;
    @(posedge clk); #1 start = 0; stop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("start_stop_busy", busy, 0);
    chk("start_stop_strobes", strobe_cnt - s0, 0);

    s0 = strobe_cnt;
    push(0, 45865, 1, 0); push(1, 27272, 1, 8); push(2, 27272, 0, 8);
    push(3, 27272, 1, 8); push(0, 45865, 1, 8); push(1, 27272, 1, 8);
    push(2, 27272, 1, 8);
    pulse_start();
    wait_strobes("rbw", s0 + 2);
    repeat (7) @(posedge clk);
    #1 wr_en = 1; wr_addr = 4'd2; wr_data = 6'd10;
    @(posedge clk); #1 wr_en = 0;
    drain("rbw");
    stop_and_check("rbw_stop");

    s0 = strobe_cnt;
    push(0, 45865, 1, 0); push(1, 27272, 1, 8); push(2, 27272, 1, 8);
    push(3, 27272, 1, 8); push(0, 45865, 1, 8); push(1, 27272, 1, 8);
    push(0, 45865, 1, 8);
    pulse_start();
    wait_strobes("loop_len", s0 + 4);
    #1 loop_len = 4'd1;
    drain("loop_len");
    stop_and_check("loop_len_stop");
    loop_len = 4'd3;

    push(0, 45865, 1, 0);
    pulse_start();
    drain("mid_reset");
    #1 mon_en = 0; rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_strobe", step_strobe, 0);
    chk("mid_rst_counter_top", counter_top, 0);
    chk("mid_rst_osc_rst", osc_rst, 1);
    chk("mid_rst_gate", gate, 0);
    @(posedge clk); #1 rst_n = 1;
    s0 = strobe_cnt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_strobes", strobe_cnt - s0, 0);
    mon_en = 1;

    push(0, 45865, 1, 0); push(1, 27272, 1, 8);
    pulse_start();
    drain("after_reset");
    stop_and_check("after_reset_stop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
